spi_boot_master: RTL and testbench

//  Synthesizable SPI master that loads and reads back L2 of the pulpino SPI slave in single or quad mode.

---
 rtl/spi_boot_pkg.sv | 31 +++
 rtl/spi_boot_clkgen.sv | 49 ++++
 rtl/spi_boot_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_boot_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_boot_pkg.sv
// spi_boot_pkg
//   Shared types and constants for the SPI boot master.
//   - state_e     : frame sequencer states (also exported on the debug port)
//   - SPI_CMD_*   : command bytes understood by the pulpino SPI slave
//   - max3        : constant helper for sizing registers from parameters
package spi_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_SETUP = 4'd1,
        ST_CMD      = 4'd2,
        ST_ADDR     = 4'd3,
        ST_DUMMY    = 4'd4,
        ST_TX       = 4'd5,
        ST_RX       = 4'd6,
        ST_CS_HOLD  = 4'd7,
        ST_GAP      = 4'd8
    } state_e;

    localparam logic [7:0] SPI_CMD_WRMEM  = 8'h02;
    localparam logic [7:0] SPI_CMD_RDMEM  = 8'h0B;
    localparam logic [7:0] SPI_CMD_WRREG0 = 8'h01;
    localparam logic [7:0] SPI_CMD_WRREG1 = 8'h11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_boot_clkgen.sv
// spi_boot_clkgen
//   SPI clock generator. While i_en is high a half-period counter runs
//   0..HALF_DIV-1 and sck toggles when it wraps. The rise/fall strobes are
//   high in the clk cycle whose closing edge makes sck rise/fall, so logic
//   in the parent that acts on a strobe updates on the same edge as sck.
//   Dropping i_en parks sck low and clears the counter.
// Ports
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : run the divider
//   o_sck          : registered SPI clock (mode 0, idle low)
//   o_rise, o_fall : edge strobes (combinational)
module spi_boot_clkgen #(
    parameter int HALF_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    assign w_tick = i_en && (r_cnt == CW'(HALF_DIV - 1));
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick &&  r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_boot_master.sv
// spi_boot_master
//   SPI master that runs one boot request (cmd, optional address, optional
//   dummy cycles, one data word) as a single chip-select frame towards the
//   pulpino SPI slave, in single-lane or quad mode.
// Handshake
//   A request transfers on the clk edge where req_valid_i && req_ready_o;
//   req_ready_o is high only in IDLE, every req_* field and qpi_i is captured
//   on that edge, and nothing is buffered while busy. rsp_valid_o is a
//   one-cycle pulse when the frame completes (GAP entry).
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   qpi_i            : 0 single lane, 1 quad
//   req_*            : request channel (valid/ready, rnw, cmd, addr, dummy, wdata)
//   rsp_valid_o      : frame complete pulse
//   rsp_rdata_o      : last read word, held until the next read completes
//   busy_o           : frame in progress
//   spi_*            : SPI pads (mode 0)
//   dbg_state_o      : current sequencer state
module spi_boot_master
    import spi_boot_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HALF_DIV = 2,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qpi_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_rnw_i,
    input  logic [7:0]        req_cmd_i,
    input  logic              req_addr_en_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [5:0]        req_dummy_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              spi_sck_o,
    output logic              spi_csn_o,
    output logic [3:0]        spi_sdo_o,
    output logic [3:0]        spi_oe_o,
    input  logic [3:0]        spi_sdi_i,
    output state_e            dbg_state_o
);

    if ((ADDR_W % 4) != 0 || (DATA_W % 4) != 0 || HALF_DIV < 1) begin : g_param_err
        $error("spi_boot_master: ADDR_W and DATA_W must be multiples of 4, HALF_DIV >= 1");
    end

    // Shift register wide enough for any tx phase, MSB aligned.
    localparam int SH_W  = max3(8, ADDR_W, DATA_W);
    // Phase counter also has to hold a 6-bit dummy count.
    localparam int CNT_W = $clog2(max3(ADDR_W, DATA_W, 63) + 1);
    localparam int TMR_W = $clog2(max3(HALF_DIV, CS_GAP, 1) + 1);

    // Reload values are "sck cycles in phase minus one".
    localparam logic [CNT_W-1:0] CMD_S  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CMD_Q  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_S = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] ADDR_Q = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0] DATA_S = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_Q = CNT_W'(DATA_W / 4 - 1);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HALF_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    state_e            r_state;
    state_e            w_next_state;
    state_e            w_after_addr;

    logic              r_qpi;
    logic              r_rnw;
    logic              r_addr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [5:0]        r_dummy;
    logic [DATA_W-1:0] r_wdata;
    logic [SH_W-1:0]   r_shift;
    logic [CNT_W-1:0]  r_bits;
    logic [TMR_W-1:0]  r_tmr;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_valid;

    logic              w_accept;
    logic              w_clk_en;
    logic              w_rise;
    logic              w_fall;
    logic              w_phase_done;
    logic [3:0]        w_oe_tx;
    logic [3:0]        w_lanes;
    logic [SH_W-1:0]   w_cmd_al;
    logic [SH_W-1:0]   w_addr_al;
    logic [SH_W-1:0]   w_data_al;

    spi_boot_clkgen #(
        .HALF_DIV (HALF_DIV)
    ) u_clkgen (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_clk_en),
        .o_sck   (spi_sck_o),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
    assign w_phase_done = w_fall && (r_bits == '0);
    assign w_cmd_al     = SH_W'(req_cmd_i) << (SH_W - 8);
    assign w_addr_al    = SH_W'(r_addr)    << (SH_W - ADDR_W);
    assign w_data_al    = SH_W'(r_wdata)   << (SH_W - DATA_W);
    assign w_oe_tx      = r_qpi ? 4'hF : 4'h1;
    assign w_lanes      = r_qpi ? r_shift[SH_W-1 -: 4] : {3'b000, r_shift[SH_W-1]};
    assign w_after_addr = !r_rnw ? ST_TX : ((r_dummy != 6'd0) ? ST_DUMMY : ST_RX);

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rdata;
    assign dbg_state_o  = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Shift phases end on the falling strobe of their last sck.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (req_valid_i)    w_next_state = ST_CS_SETUP;
            ST_CS_SETUP: if (r_tmr == '0)    w_next_state = ST_CMD;
            ST_CMD:      if (w_phase_done)   w_next_state = r_addr_en ? ST_ADDR : w_after_addr;
            ST_ADDR:     if (w_phase_done)   w_next_state = w_after_addr;
            ST_DUMMY:    if (w_phase_done)   w_next_state = ST_RX;
            ST_TX,
            ST_RX:       if (w_phase_done)   w_next_state = ST_CS_HOLD;
            ST_CS_HOLD:  if (r_tmr == '0)    w_next_state = ST_GAP;
            ST_GAP:      if (r_tmr == '0)    w_next_state = ST_IDLE;
            default:                         w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state. Lanes are forced to 0 whenever not driven.
    always_comb begin
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        spi_csn_o   = 1'b0;
        spi_oe_o    = 4'h0;
        w_clk_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                spi_csn_o   = 1'b1;
            end
            ST_GAP:      spi_csn_o = 1'b1;
            ST_CS_SETUP: spi_oe_o  = w_oe_tx;
            ST_CMD,
            ST_ADDR,
            ST_TX: begin
                spi_oe_o = w_oe_tx;
                w_clk_en = 1'b1;
            end
            ST_DUMMY,
            ST_RX:       w_clk_en  = 1'b1;
            default: ;
        endcase
        spi_sdo_o = w_lanes & spi_oe_o;
    end

    // Datapath: request capture, per-phase reloads, shift-out, shift-in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_qpi       <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr_en   <= 1'b0;
            r_addr      <= '0;
            r_dummy     <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_bits      <= '0;
            r_tmr       <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_qpi     <= qpi_i;
                r_rnw     <= req_rnw_i;
                r_addr_en <= req_addr_en_i;
                r_addr    <= req_addr_i;
                r_dummy   <= req_dummy_i;
                r_wdata   <= req_wdata_i;
                // Command MSB is on the lanes for the whole CS_SETUP window.
                r_shift   <= w_cmd_al;
                r_bits    <= qpi_i ? CMD_Q : CMD_S;
                r_tmr     <= HOLD_LD;
            end else begin
                if (r_tmr != '0) begin
                    r_tmr <= r_tmr - TMR_W'(1);
                end
                if (w_fall) begin
                    if (r_bits == '0) begin
                        case (w_next_state)
                            ST_ADDR: begin
                                r_shift <= w_addr_al;
                                r_bits  <= r_qpi ? ADDR_Q : ADDR_S;
                            end
                            ST_TX: begin
                                r_shift <= w_data_al;
                                r_bits  <= r_qpi ? DATA_Q : DATA_S;
                            end
                            ST_DUMMY:   r_bits <= CNT_W'(r_dummy) - CNT_W'(1);
                            ST_RX:      r_bits <= r_qpi ? DATA_Q : DATA_S;
                            ST_CS_HOLD: r_tmr  <= HOLD_LD;
                            default: ;
                        endcase
                    end else begin
                        r_bits  <= r_bits - CNT_W'(1);
                        r_shift <= r_qpi ? (r_shift << 4) : (r_shift << 1);
                    end
                end
                if (w_rise && r_state == ST_RX) begin
                    // Single lane reads come back on sdi[1] (slave MISO).
                    r_rx <= r_qpi ? ((r_rx << 4) | DATA_W'(spi_sdi_i))
                                  : ((r_rx << 1) | DATA_W'(spi_sdi_i[1]));
                end
                if (r_state == ST_CS_HOLD && w_next_state == ST_GAP) begin
                    r_rsp_valid <= 1'b1;
                    r_tmr       <= GAP_LD;
                    if (r_rnw) begin
                        r_rdata <= r_rx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_boot_master.sv
// tb_spi_boot_master
//   Directed bench for spi_boot_master: a behavioural SPI slave records the
//   bits clocked out while lanes are driven and returns a programmed read word,
//   frame lengths are counted in clk cycles, and read data goes through an
//   expected queue. A second instance with HALF_DIV=1 covers the fast divider.
module tb_spi_boot_master;
    import spi_boot_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              qpi = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_rnw = 1'b0;
    logic [7:0]        req_cmd = 8'h00;
    logic              req_addr_en = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [5:0]        req_dummy = 6'd0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              sck;
    logic              csn;
    logic [3:0]        sdo;
    logic [3:0]        oe;
    logic [3:0]        sdi;
    state_e            dbg_state;

    logic              f_valid = 1'b0;
    logic              f_ready;
    logic              f_rsp_valid;
    logic [DATA_W-1:0] f_rsp_rdata;
    logic              f_busy;
    logic              f_sck;
    logic              f_csn;
    logic [3:0]        f_sdo;
    logic [3:0]        f_oe;
    logic [3:0]        f_sdi;
    state_e            f_dbg_state;

    spi_boot_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALF_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .rst_n(rst_n), .qpi_i(qpi),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
        .req_cmd_i(req_cmd), .req_addr_en_i(req_addr_en), .req_addr_i(req_addr),
        .req_dummy_i(req_dummy), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
        .spi_sck_o(sck), .spi_csn_o(csn), .spi_sdo_o(sdo), .spi_oe_o(oe),
        .spi_sdi_i(sdi), .dbg_state_o(dbg_state)
    );

    spi_boot_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALF_DIV(1), .CS_GAP(4)) dut_f (
        .clk(clk), .rst_n(rst_n), .qpi_i(qpi),
        .req_valid_i(f_valid), .req_ready_o(f_ready), .req_rnw_i(req_rnw),
        .req_cmd_i(req_cmd), .req_addr_en_i(req_addr_en), .req_addr_i(req_addr),
        .req_dummy_i(req_dummy), .req_wdata_i(req_wdata),
        .rsp_valid_o(f_rsp_valid), .rsp_rdata_o(f_rsp_rdata), .busy_o(f_busy),
        .spi_sck_o(f_sck), .spi_csn_o(f_csn), .spi_sdo_o(f_sdo), .spi_oe_o(f_oe),
        .spi_sdi_i(f_sdi), .dbg_state_o(f_dbg_state)
    );

    // ---------------- slave model (main DUT) ----------------
    logic          slv_qpi = 1'b0;
    int            slv_pre = 0;
    logic [31:0]   slv_rdata = '0;
    int            rise_cnt = 0;
    logic [127:0]  cap = '0;
    int            cap_n = 0;
    int            oe0_n = 0;
    int            oef_n = 0;
    int            k_idx;
    logic [31:0]   slv_tmp;

    // csn falling starts a frame; each sck rise records driven lanes.
    always @(negedge csn or posedge sck) begin
        if (!sck) begin
            rise_cnt <= 0;
            cap      <= '0;
            cap_n    <= 0;
            oe0_n    <= 0;
            oef_n    <= 0;
        end else if (!csn) begin
            if (oe == 4'h0) begin
                oe0_n <= oe0_n + 1;
            end else begin
                if (oe == 4'hF) oef_n <= oef_n + 1;
                if (slv_qpi) begin
                    cap   <= (cap << 4) | 128'(sdo);
                    cap_n <= cap_n + 4;
                end else begin
                    cap   <= (cap << 1) | 128'(sdo[0]);
                    cap_n <= cap_n + 1;
                end
            end
            rise_cnt <= rise_cnt + 1;
        end
    end

    // Read data presented MSB first once the pre-data sck cycles are done.
    always_comb begin
        k_idx   = rise_cnt - slv_pre;
        slv_tmp = 32'h0;
        sdi     = 4'h0;
        if (k_idx >= 0 && k_idx < 32) begin
            slv_tmp = slv_rdata << (slv_qpi ? 4 * k_idx : k_idx);
            sdi     = slv_qpi ? slv_tmp[31:28] : {2'b00, slv_tmp[31], 1'b0};
        end
    end

    // ---------------- slave model (HALF_DIV=1 DUT, quad reads only) ----------------
    int            f_pre = 0;
    logic [31:0]   f_rdata = '0;
    int            f_rise = 0;
    int            f_k;
    logic [31:0]   f_tmp;

    always @(negedge f_csn or posedge f_sck) begin
        if (!f_sck)      f_rise <= 0;
        else if (!f_csn) f_rise <= f_rise + 1;
    end

    always_comb begin
        f_k   = f_rise - f_pre;
        f_tmp = 32'h0;
        f_sdi = 4'h0;
        if (f_k >= 0 && f_k < 8) begin
            f_tmp = f_rdata << (4 * f_k);
            f_sdi = f_tmp[31:28];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_rd;
    logic [DATA_W-1:0] last_rd = '0;
    logic [DATA_W-1:0] rd_at_rsp;
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cycles;
    int rsp_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_frame(input logic rnw, input logic q, input logic [7:0] cmd,
                             input logic aen, input logic [31:0] addr, input logic [5:0] dmy,
                             input logic [31:0] wd, input logic [31:0] sdata);
        int cyc;
        @(negedge clk);
        qpi = q; req_rnw = rnw; req_cmd = cmd; req_addr_en = aen;
        req_addr = addr; req_dummy = dmy; req_wdata = wd;
        slv_qpi   = q;
        slv_rdata = sdata;
        slv_pre   = (q ? 2 : 8) + (aen ? (q ? 8 : 32) : 0) + (rnw ? int'(dmy) : 0);
        if (rnw) exp_q.push_back(sdata);
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        req_valid   = 1'b0;
        busy_cycles = 0;
        rsp_cnt     = 0;
        cyc         = 0;
        while (busy && cyc < 5000) begin
            busy_cycles++;
            if (rsp_valid) begin
                rsp_cnt++;
                rd_at_rsp = rsp_rdata;
            end
            @(negedge clk);
            cyc++;
        end
        check("frame_timeout", 128'(cyc >= 5000), 128'(0));
        if (rnw) begin
            exp_rd = exp_q.pop_front();
            check("rdata", 128'(rd_at_rsp), 128'(exp_rd));
            last_rd = exp_rd;
        end else begin
            check("wr_keeps_rdata", 128'(rsp_rdata), 128'(last_rd));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    int acc;
    int falls;
    int gap;
    int cyc;
    logic prev_csn;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset values (rst_n still low)
        check("rst_ready",  128'(req_ready), 128'(1));
        check("rst_busy",   128'(busy),      128'(0));
        check("rst_csn",    128'(csn),       128'(1));
        check("rst_sck",    128'(sck),       128'(0));
        check("rst_oe",     128'(oe),        128'(0));
        check("rst_sdo",    128'(sdo),       128'(0));
        check("rst_rsp",    128'(rsp_valid), 128'(0));
        check("rst_rdata",  128'(rsp_rdata), 128'(0));
        rst_n = 1'b1;

        // Single write: 72 bits, 2*2*72+2*2+4 = 296 clk
        run_frame(1'b0, 1'b0, SPI_CMD_WRMEM, 1'b1, 32'h0000_0010, 6'd0, 32'hDEAD_BEEF, 32'h0);
        check("wr1_bits",   128'(cap_n),       128'(72));
        check("wr1_stream", cap,               128'h02_0000_0010_DEAD_BEEF);
        check("wr1_sck",    128'(rise_cnt),    128'(72));
        check("wr1_frame",  128'(busy_cycles), 128'(296));
        check("wr1_rsp",    128'(rsp_cnt),     128'(1));
        check("wr1_idle_csn", 128'(csn),       128'(1));

        // Quad read: 2+8+32+8 = 50 sck, frame 4*50+8 = 208
        run_frame(1'b1, 1'b1, SPI_CMD_RDMEM, 1'b1, 32'h0010_0000, 6'd32, 32'h0, 32'h1234_5678);
        check("qrd_stream", cap,               128'h0B_0010_0000);
        check("qrd_oe_off", 128'(oe0_n),       128'(40));
        check("qrd_oe_on",  128'(oef_n),       128'(10));
        check("qrd_frame",  128'(busy_cycles), 128'(208));
        check("qrd_rsp",    128'(rsp_cnt),     128'(1));

        // No-address single write: 8+32 sck, frame 4*40+8 = 168; rdata kept
        run_frame(1'b0, 1'b0, SPI_CMD_WRREG0, 1'b0, 32'hFFFF_FFFF, 6'd0, 32'hCAFE_F00D, 32'h0);
        check("noaddr_sck",    128'(rise_cnt),    128'(40));
        check("noaddr_cmd",    128'(cap[39:32]),  128'(8'h01));
        check("noaddr_stream", cap,               128'h01_CAFE_F00D);
        check("noaddr_frame",  128'(busy_cycles), 128'(168));

        // Back-to-back with req_valid held high
        @(negedge clk);
        qpi = 1'b0; req_rnw = 1'b0; req_cmd = SPI_CMD_WRREG1; req_addr_en = 1'b0;
        req_wdata = 32'h1122_3344; slv_qpi = 1'b0;
        req_valid = 1'b1;
        acc = 0; falls = 0; gap = 0; cyc = 0; rsp_cnt = 0; prev_csn = csn;
        while (cyc < 2000 && !(acc == 2 && !busy)) begin
            if (req_valid && req_ready) acc++;
            if (prev_csn && !csn) falls++;
            if (falls == 1 && csn) gap++;
            if (rsp_valid) rsp_cnt++;
            prev_csn = csn;
            @(negedge clk);
            cyc++;
            if (acc == 2 && busy) req_valid = 1'b0;
        end
        check("b2b_timeout", 128'(cyc >= 2000), 128'(0));
        check("b2b_accepts", 128'(acc),         128'(2));
        check("b2b_csn_gap", 128'(gap),         128'(5));
        check("b2b_rsp",     128'(rsp_cnt),     128'(2));
        repeat (10) @(negedge clk);
        check("b2b_no_extra", 128'(busy),       128'(0));

        // Reset in the middle of the address phase
        @(negedge clk);
        qpi = 1'b0; req_rnw = 1'b0; req_cmd = SPI_CMD_WRMEM; req_addr_en = 1'b1;
        req_addr = 32'hAAAA_5555; req_wdata = 32'h0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_csn_low", 128'(csn), 128'(0));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_csn",  128'(csn),  128'(1));
        check("mid_rst_sck",  128'(sck),  128'(0));
        check("mid_rst_oe",   128'(oe),   128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        rsp_cnt = 0;
        repeat (20) begin
            if (rsp_valid) rsp_cnt++;
            @(negedge clk);
        end
        check("mid_rst_no_rsp", 128'(rsp_cnt),   128'(0));
        check("mid_rst_rdata",  128'(rsp_rdata), 128'(0));
        last_rd = '0;

        // Single read after reset: 8+32+32 sck, frame 296
        run_frame(1'b1, 1'b0, SPI_CMD_RDMEM, 1'b1, 32'h1C00_8000, 6'd0, 32'h0, 32'h5A0F_F0C3);
        check("srd_stream", cap,               128'h0B_1C00_8000);
        check("srd_oe_off", 128'(oe0_n),       128'(32));
        check("srd_frame",  128'(busy_cycles), 128'(296));
        check("srd_rsp",    128'(rsp_cnt),     128'(1));

        // HALF_DIV=1 quad read: 2+8+8+8 = 26 sck, frame 2*26+2+4 = 58
        @(negedge clk);
        qpi = 1'b1; req_rnw = 1'b1; req_cmd = SPI_CMD_RDMEM; req_addr_en = 1'b1;
        req_addr = 32'h0000_0040; req_dummy = 6'd8;
        f_pre = 18; f_rdata = 32'hA5A5_A5A5;
        check("f_ready", 128'(f_ready), 128'(1));
        f_valid = 1'b1;
        @(negedge clk);
        f_valid = 1'b0;
        busy_cycles = 0; rsp_cnt = 0; cyc = 0;
        while (f_busy && cyc < 2000) begin
            busy_cycles++;
            if (f_rsp_valid) begin
                rsp_cnt++;
                rd_at_rsp = f_rsp_rdata;
            end
            @(negedge clk);
            cyc++;
        end
        check("f_timeout", 128'(cyc >= 2000),  128'(0));
        check("f_frame",   128'(busy_cycles),  128'(58));
        check("f_rsp",     128'(rsp_cnt),      128'(1));
        check("f_rdata",   128'(rd_at_rsp),    128'(32'hA5A5_A5A5));
        check("main_rdata_untouched", 128'(rsp_rdata), 128'(32'h5A0F_F0C3));
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
